ps2_host_tx: RTL and testbench

PS/2 host-to-device transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xF4 enable) from the CPU to the keyboard. It is the opposite direction of the existing PS/2 receive path. It sits beside the keyboard receiver in the keyboard clock domain and drives the PS/2 clock and data lines open-drain. The CPU writes a byte and polls `busy`/`err` through the memory-mapped keyboard region. While it transmits, it tells the receiver to ignore line activity.

---
 rtl/ps2_pkg.sv | 22 ++
 rtl/ps2_line_sync.sv | 26 ++
 rtl/ps2_host_tx.sv | 112 +++++++++++
 tb/tb_ps2_host_tx.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 states, frame layout, default timing and command bytes.
package ps2_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQ,
    ST_SEND,
    ST_ACK,
    ST_WAITIDLE
  } ps2_state_e;
  localparam int FRAME_LEN = 11;
  localparam int DEF_CLK_FREQ = 10_000_000;
  localparam int DEF_INHIBIT_CYCLES = DEF_CLK_FREQ / 10_000;
  localparam int DEF_TIMEOUT_CYCLES = DEF_CLK_FREQ / 500;
  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ENABLE = 8'hF4;
  localparam logic [7:0] CMD_RESET = 8'hFF;
  // Start bit is driven by REQ, so the shifted frame holds only stop, parity, data.
  function automatic logic [FRAME_LEN-2:0] make_frame(input logic [7:0] d);
    return {1'b1, ~^d, d};
  endfunction
endpackage

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: two-flop synchronisers for the PS/2 pins plus clock falling-edge detect.
module ps2_line_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic clk_i,
  input  logic data_i,
  output logic clk_o,
  output logic data_o,
  output logic fall_o
);
  logic [1:0] c_q, d_q;
  logic prev_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      c_q <= 2'b11;
      d_q <= 2'b11;
      prev_q <= 1'b1;
    end else begin
      c_q <= {c_q[0], clk_i};
      d_q <= {d_q[0], data_i};
      prev_q <= c_q[1];
    end
  assign clk_o = c_q[1];
  assign data_o = d_q[1];
  assign fall_o = prev_q & ~c_q[1];
endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter with inhibit, ACK check and timeout.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int CLK_FREQ = DEF_CLK_FREQ,
  parameter int INHIBIT_CYCLES = CLK_FREQ / 10_000,
  parameter int TIMEOUT_CYCLES = CLK_FREQ / 500
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       rx_inhibit
);
  localparam int CW = $clog2((INHIBIT_CYCLES > TIMEOUT_CYCLES ? INHIBIT_CYCLES : TIMEOUT_CYCLES) + 1);
  ps2_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0] bit_q, bit_d;
  logic [FRAME_LEN-2:0] frame_q, frame_d;
  logic dat_q, dat_d, err_q, err_d, done_q, done_d;
  logic sclk, sdat, fall, tmo;
  ps2_line_sync u_sync (
    .clk(clk),
    .rst_n(clrn),
    .clk_i(ps2_clk_in),
    .data_i(ps2_data_in),
    .clk_o(sclk),
    .data_o(sdat),
    .fall_o(fall)
  );
  assign tmo = cnt_q == CW'(TIMEOUT_CYCLES - 1);
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    bit_d = bit_q;
    frame_d = frame_q;
    dat_d = dat_q;
    err_d = err_q;
    done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        dat_d = 1'b0;
        if (wr_en) begin
          frame_d = make_frame(wr_data);
          err_d = 1'b0;
          state_d = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(INHIBIT_CYCLES - 1)) begin
          cnt_d = '0;
          dat_d = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_REQ: state_d = ST_SEND;
      default: begin
        // Timeout has priority over any line event in the same cycle.
        cnt_d = cnt_q + 1'b1;
        if (tmo) begin
          dat_d = 1'b0;
          err_d = 1'b1;
          state_d = ST_IDLE;
        end else if (state_q == ST_SEND && fall) begin
          dat_d = ~frame_q[bit_q];
          bit_d = bit_q + 1'b1;
          if (bit_q == 4'd9) state_d = ST_ACK;
        end else if (state_q == ST_ACK && fall) begin
          if (sdat) err_d = 1'b1;
          state_d = ST_WAITIDLE;
        end else if (state_q == ST_WAITIDLE && sclk && sdat) begin
          done_d = ~err_q;
          state_d = ST_IDLE;
        end
      end
    endcase
  end
  always_ff @(posedge clk or negedge clrn)
    if (!clrn) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      frame_q <= '0;
      dat_q <= 1'b0;
      err_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      frame_q <= frame_d;
      dat_q <= dat_d;
      err_q <= err_d;
      done_q <= done_d;
    end
  assign busy = state_q != ST_IDLE;
  assign rx_inhibit = busy;
  assign ps2_clk_oe = state_q == ST_INHIBIT || state_q == ST_REQ;
  assign ps2_data_oe = dat_q;
  assign done = done_q;
  assign err = err_q;
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: drives ps2_host_tx against an open-drain PS/2 device model and checks frames and status.
module tb_ps2_host_tx;
  localparam int INH = 200;
  localparam int TMO = 12000;
  logic clk = 1'b0, clrn = 1'b0, wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic dev_clk_low = 1'b0, dev_dat_low = 1'b0;
  logic ps2_clk_oe, ps2_data_oe, busy, done, err, rx_inhibit;
  logic clk_pin, dat_pin;
  int vectors = 0, miscompares = 0, done_cnt = 0;
  assign clk_pin = ~(ps2_clk_oe | dev_clk_low);
  assign dat_pin = ~(ps2_data_oe | dev_dat_low);
  always #5 clk = ~clk;
  always @(negedge clk) if (done === 1'b1) done_cnt++;
  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk),
    .clrn(clrn),
    .wr_en(wr_en),
    .wr_data(wr_data),
    .ps2_clk_in(clk_pin),
    .ps2_data_in(dat_pin),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .busy(busy),
    .done(done),
    .err(err),
    .rx_inhibit(rx_inhibit)
  );
  function automatic logic [10:0] exp_frame(input logic [7:0] b);
    logic [10:0] f;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = b[i];
    f[9] = ($countones(b) % 2) == 0;
    f[10] = 1'b1;
    return f;
  endfunction
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic write_byte(input logic [7:0] b);
    wr_data = b;
    wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask
  task automatic check_start(input logic [7:0] b);
    write_byte(b);
    vectors++;
    if (busy !== 1'b1 || ps2_clk_oe !== 1'b1 || ps2_data_oe !== 1'b0 || err !== 1'b0 || rx_inhibit !== 1'b1) begin
      miscompares++;
      $display("FAIL start_cycle1 busy=%b clk_oe=%b data_oe=%b err=%b rx_inh=%b required 1 1 0 0 1", busy, ps2_clk_oe, ps2_data_oe, err, rx_inhibit);
    end
    tick(INH - 1);
    vectors++;
    if (ps2_clk_oe !== 1'b1 || ps2_data_oe !== 1'b0) begin
      miscompares++;
      $display("FAIL inhibit_end clk_oe=%b data_oe=%b required 1 0", ps2_clk_oe, ps2_data_oe);
    end
    tick(1);
    vectors++;
    if (ps2_clk_oe !== 1'b1 || ps2_data_oe !== 1'b1) begin
      miscompares++;
      $display("FAIL request clk_oe=%b data_oe=%b required 1 1", ps2_clk_oe, ps2_data_oe);
    end
    tick(1);
    vectors++;
    if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b1) begin
      miscompares++;
      $display("FAIL clock_release clk_oe=%b data_oe=%b required 0 1", ps2_clk_oe, ps2_data_oe);
    end
  endtask
  // Device reads each bit while its clock is low; ACK is driven ahead of the 11th fall.
  task automatic run_device(input int h, input bit ack_low, input int abort_at, output logic [10:0] rx);
    rx = '0;
    tick(h);
    rx[0] = dat_pin;
    for (int k = 1; k <= 11; k++) begin
      dev_clk_low = 1'b1;
      if (k == abort_at) begin
        tick(10);
        #3 clrn = 1'b0;
        #1;
        vectors++;
        if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0 || busy !== 1'b0) begin
          miscompares++;
          $display("FAIL async_reset clk_oe=%b data_oe=%b busy=%b required 0 0 0", ps2_clk_oe, ps2_data_oe, busy);
        end
        @(negedge clk);
        clrn = 1'b1;
        dev_clk_low = 1'b0;
        dev_dat_low = 1'b0;
        return;
      end
      tick(h);
      if (k <= 10) rx[k] = dat_pin;
      dev_clk_low = 1'b0;
      if (k == 10) begin
        tick(h / 2);
        dev_dat_low = ack_low;
        tick(h - h / 2);
      end else tick(h);
    end
    dev_dat_low = 1'b0;
  endtask
  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 20000) begin
      tick(1);
      n++;
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_idle busy=%b required 0 within 20000 cycles", tag, busy);
    end
  endtask
  task automatic xfer(input logic [7:0] b, input int h, input bit ack_low, input bit stray, output logic [10:0] rx, output int dones);
    int d0;
    d0 = done_cnt;
    check_start(b);
    fork
      run_device(h, ack_low, 0, rx);
      if (stray) begin
        tick(1000);
        vectors++;
        if (busy !== 1'b1) begin
          miscompares++;
          $display("FAIL stray_busy busy=%b required 1", busy);
        end
        write_byte(8'h55);
      end
    join
    wait_idle("xfer");
    tick(2);
    dones = done_cnt - d0;
  endtask
  task automatic check_result(input string tag, input logic [7:0] b, input logic [10:0] rx, input int dones, input bit ack_low);
    vectors++;
    if (rx !== exp_frame(b)) begin
      miscompares++;
      $display("FAIL %s_frame got=%b required=%b", tag, rx, exp_frame(b));
    end
    vectors++;
    if (dones != (ack_low ? 1 : 0)) begin
      miscompares++;
      $display("FAIL %s_done pulses=%0d required=%0d", tag, dones, ack_low ? 1 : 0);
    end
    vectors++;
    if (err !== !ack_low || busy !== 1'b0 || ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_status err=%b busy=%b clk_oe=%b data_oe=%b required %b 0 0 0", tag, err, busy, ps2_clk_oe, ps2_data_oe, !ack_low);
    end
  endtask
  task automatic test_reset();
    tick(2);
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0 || rx_inhibit !== 1'b0) begin
      miscompares++;
      $display("FAIL reset busy=%b done=%b err=%b clk_oe=%b data_oe=%b rx_inh=%b required all 0", busy, done, err, ps2_clk_oe, ps2_data_oe, rx_inhibit);
    end
    clrn = 1'b1;
    tick(2);
  endtask
  task automatic test_set_leds();
    logic [10:0] rx;
    int d;
    xfer(8'hED, 400, 1'b1, 1'b0, rx, d);
    check_result("set_leds", 8'hED, rx, d, 1'b1);
  endtask
  task automatic test_parity();
    logic [10:0] rx;
    int d;
    xfer(8'h01, 150, 1'b1, 1'b0, rx, d);
    check_result("parity0", 8'h01, rx, d, 1'b1);
    xfer(8'hF4, 150, 1'b1, 1'b0, rx, d);
    check_result("enable", 8'hF4, rx, d, 1'b1);
  endtask
  task automatic test_nack();
    logic [10:0] rx;
    int d;
    xfer(8'hF4, 120, 1'b0, 1'b0, rx, d);
    check_result("nack", 8'hF4, rx, d, 1'b0);
  endtask
  task automatic test_timeout();
    int d0;
    d0 = done_cnt;
    check_start(8'hA5);
    tick(TMO - 1);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_early busy=%b required 1", busy);
    end
    tick(1);
    vectors++;
    if (busy !== 1'b0 || err !== 1'b1 || ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout busy=%b err=%b clk_oe=%b data_oe=%b required 0 1 0 0", busy, err, ps2_clk_oe, ps2_data_oe);
    end
    tick(2);
    vectors++;
    if (done_cnt != d0) begin
      miscompares++;
      $display("FAIL timeout_done pulses=%0d required 0", done_cnt - d0);
    end
  endtask
  task automatic test_ignore_busy();
    logic [10:0] rx;
    int d, d1;
    xfer(8'hED, 150, 1'b1, 1'b1, rx, d);
    check_result("busy_write", 8'hED, rx, d, 1'b1);
    d1 = done_cnt;
    tick(2000);
    vectors++;
    if (busy !== 1'b0 || done_cnt != d1) begin
      miscompares++;
      $display("FAIL busy_write_extra busy=%b extra_done=%0d required 0 0", busy, done_cnt - d1);
    end
  endtask
  task automatic test_reset_mid();
    logic [10:0] rx;
    int d;
    check_start(8'hED);
    run_device(150, 1'b1, 5, rx);
    tick(5);
    vectors++;
    if (busy !== 1'b0 || err !== 1'b0 || ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset busy=%b err=%b clk_oe=%b data_oe=%b required 0 0 0 0", busy, err, ps2_clk_oe, ps2_data_oe);
    end
    xfer(8'hFF, 150, 1'b1, 1'b0, rx, d);
    check_result("reset_cmd", 8'hFF, rx, d, 1'b1);
  endtask
  task automatic test_random();
    logic [10:0] rx;
    logic [7:0] b;
    int d, h;
    bit a;
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom);
      h = $urandom_range(200, 60);
      a = 1'($urandom_range(1, 0) != 0 || i == 0);
      xfer(b, h, a, 1'b0, rx, d);
      check_result("random", b, rx, d, a);
    end
  endtask
  initial begin
    test_reset();
    test_set_leds();
    test_parity();
    test_nack();
    test_timeout();
    test_ignore_busy();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
